mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
// - Sits directly below the Riscv141 core. Consumes its icache_*/dcache_* request ports and produces the core's stall input.
// - Serialises instruction-fetch and data requests onto one single-ported backing memory with a valid/ready request channel and a valid-only response channel.
// - Holds stall high until every request presented in the current cycle has completed.
// PARAMETERS
// - ADDR_W   14  width of the memory word address (byte addr bits [ADDR_W+1:2])
// - D_FIRST  1   1: serve data request before fetch when both present; 0: fetch first
// PORTS
// - clk             in   1       system clock
// - reset           in   1       synchronous, active-high reset
// - icache_addr     in   32      fetch byte address
// - icache_re       in   1       fetch request
// - icache_dout     out  32      fetched instruction
// - dcache_addr     in   32      data byte address
// - dcache_re       in   1       data read request
// - dcache_we       in   4       byte write enables; any bit set = write request
// - dcache_din      in   32      store data, already lane-aligned
// - dcache_dout     out  32      load data, full word
// - stall           out  1       freeze core pipeline
// - mem_req_valid   out  1       memory request valid
// - mem_req_ready   in   1       memory accepts request this cycle
// - mem_req_rw      out  1       1 = write, 0 = read
// - mem_req_addr    out  ADDR_W  word address
// - mem_req_data    out  32      write data
// - mem_req_mask    out  4       write byte mask
// - mem_resp_valid  in   1       read data valid (reads only; writes get no response)
// - mem_resp_data   in   32      read data
// BEHAVIOUR
// - Reset state and outputs:
//   - Reset forces state IDLE.
//   - stall=0, mem_req_valid=0, icache_dout=0, dcache_dout=0.
//   - Any pending work is dropped, including when reset arrives mid-transaction.
// - States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE. At most 1 outstanding memory request.
// - IDLE:
//   - Pending set = {data if dcache_re|(|dcache_we)} + {fetch if icache_re}.
//   - Empty set: stall=0, stay in IDLE.
//   - Otherwise: stall=1 (combinational); latch addr/din/we/re of both ports; go to the first REQ state per D_FIRST.
// - *_REQ:
//   - mem_req_valid=1 with latched fields; rw=1 iff latched we!=0; a write wins if re and we are both set.
//   - Request fields are stable until mem_req_ready=1.
//   - On handshake: read -> matching *_WAIT; write -> next pending REQ, or DONE if none remain.
// - *_WAIT:
//   - mem_req_valid=0.
//   - On mem_resp_valid: capture mem_resp_data into dcache_dout or icache_dout, then go to next pending REQ or DONE.
//   - No timeout.
// - DONE: stall=0 for exactly one cycle; the core samples *_dout at this edge. Go to IDLE.
// - stall=1 in every state except IDLE-with-no-request and DONE.
// - The core holds its request inputs stable while stall=1. The block uses only the values latched in IDLE.
// - mem_resp_valid outside *_WAIT is ignored. Unserved dout registers hold their previous value.
// - mem_req_addr = latched_addr[ADDR_W+1:2]. Low 2 bits and bits above ADDR_W+1 are ignored; no misalignment fault.
// - Latency with ready=1 and response 1 cycle after handshake:
//   - single read: 3 stall cycles
//   - single write: 2 stall cycles
//   - read+fetch: 5 stall cycles
//   - write+fetch: 4 stall cycles
// TESTING
// 1. Fetch only, icache_addr=0x0000_2004, ready=1, resp 1 cycle later with 0x00500093:
//    -> req addr 0x801, rw=0; stall high 3 cycles; icache_dout=0x00500093 in DONE.
// 2. Fetch 0x100 + load 0x2008, D_FIRST=1:
//    -> data req (addr 0x802) precedes fetch req (addr 0x40); both douts correct; stall high 5 cycles.
// 3. Store we=4'b0011, din=0xDEAD_BEEF, addr 0x10, ready low 3 cycles:
//    -> valid held 4 cycles with addr 0x4, mask 0011, data stable; no WAIT state; stall drops after handshake+1.
// 4. Stray mem_resp_valid pulse while IDLE and while in D_REQ:
//    -> ignored; douts unchanged.
// 5. Reset asserted during I_WAIT:
//    -> next cycle stall=0, mem_req_valid=0, douts=0; late response ignored; next request served normally.
// 6. re=1 and we=4'b1111 together:
//    -> single write request only; dcache_dout unchanged.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - serialises core fetch and data requests onto one backing memory
module mem_req_arbiter #(
  parameter int ADDR_W  = 14,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       icache_addr,
  input  logic              icache_re,
  output logic [31:0]       icache_dout,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [31:0]       d_din_q, d_din_d;
  logic [3:0]        d_we_q, d_we_d;
  logic              d_pend_q, d_pend_d;
  logic              i_pend_q, i_pend_d;
  logic [31:0]       i_dout_q, i_dout_d;
  logic [31:0]       d_dout_q, d_dout_d;
  logic              d_new;

  // Only the word-address bits reach memory; the byte offset and high bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[31:ADDR_W+2], icache_addr[1:0],
                              dcache_addr[31:ADDR_W+2], dcache_addr[1:0]};

  assign d_new       = dcache_re | (|dcache_we);
  assign icache_dout = i_dout_q;
  assign dcache_dout = d_dout_q;

  // State and latched request registers; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      d_addr_q <= '0;
      i_addr_q <= '0;
      d_din_q  <= '0;
      d_we_q   <= '0;
      d_pend_q <= 1'b0;
      i_pend_q <= 1'b0;
      i_dout_q <= '0;
      d_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      d_addr_q <= d_addr_d;
      i_addr_q <= i_addr_d;
      d_din_q  <= d_din_d;
      d_we_q   <= d_we_d;
      d_pend_q <= d_pend_d;
      i_pend_q <= i_pend_d;
      i_dout_q <= i_dout_d;
      d_dout_q <= d_dout_d;
    end
  end

  // Next-state logic and memory/stall outputs; one request in flight at a time.
  always_comb begin
    state_d       = state_q;
    d_addr_d      = d_addr_q;
    i_addr_d      = i_addr_q;
    d_din_d       = d_din_q;
    d_we_d        = d_we_q;
    d_pend_d      = d_pend_q;
    i_pend_d      = i_pend_q;
    i_dout_d      = i_dout_q;
    d_dout_d      = d_dout_q;
    stall         = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = d_addr_q;
    mem_req_data  = d_din_q;
    mem_req_mask  = d_we_q;

    case (state_q)
      IDLE: begin
        if (!d_new && !icache_re) begin
          stall = 1'b0;
        end else begin
          d_addr_d = dcache_addr[ADDR_W+1:2];
          i_addr_d = icache_addr[ADDR_W+1:2];
          d_din_d  = dcache_din;
          d_we_d   = dcache_we;
          d_pend_d = d_new;
          i_pend_d = icache_re;
          state_d  = (d_new && (D_FIRST || !icache_re)) ? D_REQ : I_REQ;
        end
      end
      D_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = |d_we_q;
        if (mem_req_ready) begin
          d_pend_d = 1'b0;
          if (|d_we_q) begin
            state_d = i_pend_q ? I_REQ : DONE;
          end else begin
            state_d = D_WAIT;
          end
        end
      end
      D_WAIT: begin
        if (mem_resp_valid) begin
          d_dout_d = mem_resp_data;
          state_d  = i_pend_q ? I_REQ : DONE;
        end
      end
      I_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = i_addr_q;
        mem_req_data  = '0;
        mem_req_mask  = '0;
        if (mem_req_ready) begin
          i_pend_d = 1'b0;
          state_d  = I_WAIT;
        end
      end
      I_WAIT: begin
        if (mem_resp_valid) begin
          i_dout_d = mem_resp_data;
          state_d  = d_pend_q ? D_REQ : DONE;
        end
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - vector table plus scoreboard bench for mem_req_arbiter
module tb_mem_req_arbiter;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              reset;
  logic [31:0]       icache_addr;
  logic              icache_re;
  logic [31:0]       icache_dout;
  logic [31:0]       dcache_addr;
  logic              dcache_re;
  logic [3:0]        dcache_we;
  logic [31:0]       dcache_din;
  logic [31:0]       dcache_dout;
  logic              stall;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic [3:0]        mem_req_mask;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;

  mem_req_arbiter #(.ADDR_W(ADDR_W), .D_FIRST(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_re;
    logic [31:0] i_addr;
    logic        d_re;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_din;
    int          ready_dly;
    bit          stray;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    int          exp_stall;
    int          exp_valid;
  } vec_t;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        mask;
    logic [31:0]       rdata;
  } req_t;

  req_t        exp_q[$];
  vec_t        vecs[7];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_i    = 32'h0;
  logic [31:0] exp_d    = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [ADDR_W-1:0] waddr(input logic [31:0] a);
    logic [31:0] s;
    s = a >> 2;
    return s[ADDR_W-1:0];
  endfunction

  task automatic clear_inputs();
    icache_re      = 1'b0;
    icache_addr    = 32'h0;
    dcache_re      = 1'b0;
    dcache_we      = 4'h0;
    dcache_addr    = 32'h0;
    dcache_din     = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    req_t        r;
    req_t        f;
    logic        d_op;
    logic        d_wr;
    int          low_left;
    int          resp_cnt;
    int          stall_n;
    int          valid_n;
    logic [31:0] resp_dat;
    bit          done;
    d_op = v.d_re | (|v.d_we);
    d_wr = |v.d_we;
    if (d_op) begin
      r.rw = d_wr; r.addr = waddr(v.d_addr); r.data = v.d_din; r.mask = v.d_we; r.rdata = v.d_rdata;
      exp_q.push_back(r);
      if (!d_wr) exp_d = v.d_rdata;
    end
    if (v.i_re) begin
      r.rw = 1'b0; r.addr = waddr(v.i_addr); r.data = 32'h0; r.mask = 4'h0; r.rdata = v.i_rdata;
      exp_q.push_back(r);
      exp_i = v.i_rdata;
    end
    @(negedge clk);
    icache_re   = v.i_re;
    icache_addr = v.i_addr;
    dcache_re   = v.d_re;
    dcache_we   = v.d_we;
    dcache_addr = v.d_addr;
    dcache_din  = v.d_din;
    low_left = v.ready_dly;
    resp_cnt = 0;
    stall_n  = 0;
    valid_n  = 0;
    resp_dat = 32'h0;
    done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      mem_req_ready = (low_left == 0);
      if (resp_cnt == 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp_dat;
      end else if (v.stray) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBADC_0DE0 + c;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
      end
      if (resp_cnt > 0) resp_cnt--;
      #1;
      if (stall) stall_n++;
      if (mem_req_valid) begin
        valid_n++;
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d unexpected_req", idx), 64'(mem_req_addr), 64'hFFFF_FFFF);
        end else begin
          f = exp_q[0];
          chk($sformatf("v%0d req_fields", idx),
              {13'h0, mem_req_rw, mem_req_addr, (mem_req_rw ? mem_req_data : 32'h0),
               (mem_req_rw ? mem_req_mask : 4'h0)},
              {13'h0, f.rw, f.addr, (f.rw ? f.data : 32'h0), (f.rw ? f.mask : 4'h0)});
          if (mem_req_ready) begin
            f = exp_q.pop_front();
            low_left = v.ready_dly;
            if (!f.rw) begin
              resp_cnt = 1;
              resp_dat = f.rdata;
            end
          end else begin
            low_left--;
          end
        end
      end
      if (!stall && stall_n > 0) begin
        done = 1'b1;
        chk($sformatf("v%0d stall_cycles", idx), 64'(stall_n), 64'(v.exp_stall));
        chk($sformatf("v%0d valid_cycles", idx), 64'(valid_n), 64'(v.exp_valid));
        chk($sformatf("v%0d icache_dout", idx), 64'(icache_dout), 64'(exp_i));
        chk($sformatf("v%0d dcache_dout", idx), 64'(dcache_dout), 64'(exp_d));
        chk($sformatf("v%0d reqs_left", idx), 64'(exp_q.size()), 64'd0);
        clear_inputs();
      end
    end
    if (!done) begin
      chk($sformatf("v%0d timeout", idx), 64'd0, 64'd1);
      exp_q.delete();
      clear_inputs();
    end
  endtask

  initial begin
    //        i_re  i_addr         d_re  d_we   d_addr         d_din          rdy stray i_rdata        d_rdata        stl vld
    vecs[0] = '{1'b1, 32'h0000_2004, 1'b0, 4'h0, 32'h0,         32'h0,         0, 1'b0, 32'h0050_0093, 32'h0,         3, 1};
    vecs[1] = '{1'b1, 32'h0000_0100, 1'b1, 4'h0, 32'h0000_2008, 32'h0,         0, 1'b0, 32'h3333_4444, 32'h1111_2222, 5, 2};
    vecs[2] = '{1'b0, 32'h0,         1'b0, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'h0,         32'h0,         5, 4};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h0000_0040, 32'h0,         2, 1'b1, 32'h0,         32'h5555_6666, 5, 3};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h0000_0044, 32'h1234_5678, 0, 1'b0, 32'h0,         32'h0,         2, 1};
    vecs[5] = '{1'b1, 32'h0000_0008, 1'b0, 4'h8, 32'hFFFF_FFFC, 32'hA5A5_0000, 0, 1'b0, 32'h7777_8888, 32'h0,         4, 2};
    vecs[6] = '{1'b1, 32'h8004_3FFC, 1'b1, 4'h0, 32'hABCD_0007, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 32'hC0FF_EE00, 5, 2};

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_valid", 64'(mem_req_valid), 64'd0);
    chk("reset_idout", 64'(icache_dout), 64'd0);
    chk("reset_ddout", 64'(dcache_dout), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Stray response while idle must not touch either dout.
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hFFFF_0000;
    #1;
    chk("stray_idle_stall", 64'(stall), 64'd0);
    chk("stray_idle_valid", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("stray_idle_idout", 64'(icache_dout), 64'(exp_i));
    chk("stray_idle_ddout", 64'(dcache_dout), 64'(exp_d));

    // Reset while a fetch is waiting for its response.
    @(negedge clk);
    icache_re     = 1'b1;
    icache_addr   = 32'h0000_0200;
    mem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ireq_valid", 64'(mem_req_valid), 64'd1);
    @(negedge clk);
    #1;
    chk("rst_iwait_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_iwait_stall", 64'(stall), 64'd1);
    reset         = 1'b1;
    icache_re     = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0BAD;
    #1;
    chk("rst_after_stall", 64'(stall), 64'd0);
    chk("rst_after_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_after_idout", 64'(icache_dout), 64'd0);
    chk("rst_after_ddout", 64'(dcache_dout), 64'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    #1;
    chk("rst_late_resp_idout", 64'(icache_dout), 64'd0);
    exp_i = 32'h0;
    exp_d = 32'h0;
    run_vec(7, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
